// File: rtl/pc_seq_if.sv
// pc_seq_if: bundle between the PC fetch sequencer and its surroundings
// (PC register, instruction memory, decode/execute stage).
//   master: the sequencer (drives pc_d/pc_en, fetch request, status)
//   slave : the environment (drives pc_q, imem_ack, stall, branch, halt/resume)
interface pc_seq_if #(
  parameter int unsigned AW = 8
) ();
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic          pc_en;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic          instr_valid;
  logic          stall;
  logic          br_take;
  logic [AW-1:0] br_target;
  logic          halt_req;
  logic          resume;
  logic          halted;
  logic          fault;

  modport master (
    input  pc_q, imem_ack, stall, br_take, br_target, halt_req, resume,
    output pc_d, pc_en, imem_req, imem_addr, instr_valid, halted, fault
  );

  modport slave (
    output pc_q, imem_ack, stall, br_take, br_target, halt_req, resume,
    input  pc_d, pc_en, imem_req, imem_addr, instr_valid, halted, fault
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter fetch sequencer for the 8-bit processor.
// Walks each instruction through FETCH (memory handshake at pc_q), ISSUE
// (instr_valid held while stalled) and UPDATE (one pc_en strobe loading the
// sequential or branch address). Supports halt/resume and a sticky
// fetch-timeout fault.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - pc_seq_if master modport (PC, imem handshake, control, status)
module pc_seq_ctrl #(
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RST_VEC  = '0,
  parameter int unsigned   MAX_WAIT = 15
) (
  input logic         clk,
  input logic         rst,
  pc_seq_if.master    bus
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StUpdate,
    StHalt,
    StFault
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.imem_addr = bus.pc_q;

  always_comb begin
    state_d         = state_q;
    wait_d          = '0;
    bus.pc_d        = bus.pc_q;
    bus.pc_en       = 1'b0;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;
    bus.fault       = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.pc_en = 1'b1;
        bus.pc_d  = RST_VEC;
        state_d   = StFetch;
      end
      StFetch: begin
        bus.imem_req = 1'b1;
        // wait_q counts earlier ack-less FETCH cycles, so an ack on the
        // MAX_WAIT-th cycle still wins over the timeout.
        if (bus.imem_ack) begin
          state_d = StIssue;
        end else if (wait_q == CW'(MAX_WAIT - 1)) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      StIssue: begin
        bus.instr_valid = 1'b1;
        if (!bus.stall) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        bus.pc_en = 1'b1;
        bus.pc_d  = bus.br_take ? bus.br_target : bus.pc_q + AW'(1);
        state_d   = bus.halt_req ? StHalt : StFetch;
      end
      StHalt: begin
        bus.halted = 1'b1;
        if (bus.resume) begin
          state_d = StFetch;
        end
      end
      StFault: begin
        bus.fault = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: self-checking bench for pc_seq_ctrl. Instructions are
// described at transaction level (wait cycles, stall cycles, branch, halt,
// resume delay); the bench derives the expected per-cycle outputs and the
// next fetch address from those numbers, and keeps its own PC register.
module tb_pc_seq_ctrl;

  localparam int unsigned AW = 8;
  localparam logic [7:0]  RV = 8'h10;
  localparam int unsigned MW = 15;

  typedef struct {
    int         w;        // ack-less FETCH cycles before the ack
    int         s;        // stalled ISSUE cycles
    bit         br;
    logic [7:0] tgt;
    bit         halt;
    int         r;        // HALT cycles before resume
    logic [7:0] exp_next; // expected next fetch address
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_seq_if #(.AW(AW)) bus ();

  pc_seq_ctrl #(
    .AW      (AW),
    .RST_VEC (RV),
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // PC register outside the sequencer.
  logic [7:0] pc_reg = 8'hA5;
  always @(posedge clk) if (bus.pc_en) pc_reg <= bus.pc_d;
  assign bus.pc_q = pc_reg;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pc;
  vec_t       tbl[13];

  task automatic check(input string name, input logic er, input logic ev, input logic een,
                       input logic eh, input logic ef, input logic [7:0] epd);
    logic [20:0] got, exp;
    got = {bus.imem_req, bus.instr_valid, bus.pc_en, bus.halted, bus.fault, bus.pc_d,
           bus.imem_addr};
    exp = {er, ev, een, eh, ef, epd, model_pc};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got req/val/en/halt/fault=%b pc_d=%h addr=%h, want %b pc_d=%h addr=%h",
               name, $time, got[20:16], got[15:8], got[7:0], exp[20:16], exp[15:8], exp[7:0]);
    end
  endtask

  // Random activity on every input; phase code overrides what matters.
  task automatic noise();
    bus.imem_ack  = 1'($urandom);
    bus.stall     = 1'($urandom);
    bus.br_take   = 1'($urandom);
    bus.br_target = 8'($urandom);
    bus.halt_req  = 1'($urandom);
    bus.resume    = 1'($urandom);
  endtask

  task automatic cyc(input string name, input logic er, input logic ev, input logic een,
                     input logic eh, input logic ef, input logic [7:0] epd);
    @(negedge clk);
    check(name, er, ev, een, eh, ef, epd);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input vec_t v);
    logic [7:0] a;
    a = model_pc;
    for (int i = 0; i <= v.w; i++) begin
      noise();
      bus.imem_ack = (i == v.w);
      cyc("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    end
    for (int j = 0; j <= v.s; j++) begin
      noise();
      bus.stall   = (j < v.s);
      bus.br_take = 1'b1;  // must be ignored outside UPDATE
      cyc("issue", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
    end
    noise();
    bus.br_take   = v.br;
    bus.br_target = v.tgt;
    bus.halt_req  = v.halt;
    cyc("update", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, v.exp_next);
    model_pc = v.exp_next;
    if (v.halt) begin
      for (int k = 0; k <= v.r; k++) begin
        noise();
        bus.resume = (k == v.r);
        cyc("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, model_pc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //            w   s  br  tgt    halt r  exp_next
    tbl[0]  = '{0,  0, 0, 8'hCC, 0, 0, 8'h11};
    tbl[1]  = '{0,  0, 0, 8'hCC, 0, 0, 8'h12};
    tbl[2]  = '{0,  0, 0, 8'hCC, 0, 0, 8'h13};
    tbl[3]  = '{1,  4, 0, 8'hCC, 0, 0, 8'h14};
    tbl[4]  = '{0,  0, 1, 8'h05, 0, 0, 8'h05};
    tbl[5]  = '{0,  0, 1, 8'h40, 0, 0, 8'h40};
    tbl[6]  = '{2,  0, 0, 8'h99, 0, 0, 8'h41};
    tbl[7]  = '{0,  0, 0, 8'hCC, 1, 3, 8'h42};
    tbl[8]  = '{0,  1, 1, 8'hFE, 1, 0, 8'hFE};
    tbl[9]  = '{0,  0, 0, 8'hCC, 0, 0, 8'hFF};
    tbl[10] = '{0,  0, 0, 8'hCC, 0, 0, 8'h00};
    tbl[11] = '{14, 0, 0, 8'hCC, 0, 0, 8'h01};
    tbl[12] = '{3,  2, 0, 8'h33, 1, 1, 8'h02};

    rst = 1'b0;
    bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.br_take = 1'b0; bus.br_target = '0;
    bus.halt_req = 1'b0; bus.resume = 1'b0;
    model_pc = 8'hA5;
    #2;
    check("reset_outputs", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RV);
    #11 rst = 1'b1;
    @(posedge clk);
    #1;
    model_pc = RV;

    for (int n = 0; n < 13; n++) run_instr(tbl[n]);

    for (int n = 0; n < 150; n++) begin
      v.w    = ($urandom_range(9, 0) == 0) ? 14 : int'($urandom_range(3, 0));
      v.s    = int'($urandom_range(3, 0));
      v.br   = ($urandom_range(3, 0) == 0);
      v.tgt  = 8'($urandom);
      v.halt = ($urandom_range(7, 0) == 0);
      v.r    = int'($urandom_range(3, 0));
      v.exp_next = v.br ? v.tgt : model_pc + 8'd1;
      run_instr(v);
    end

    // Timeout: MAX_WAIT ack-less FETCH cycles, then sticky fault.
    for (int i = 0; i < int'(MW); i++) begin
      noise();
      bus.imem_ack = 1'b0;
      cyc("timeout_fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, model_pc);
    end
    for (int i = 0; i < 4; i++) begin
      noise();
      bus.imem_ack = 1'b1;
      bus.resume   = 1'b1;
      cyc("fault_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_pc);
    end

    rst = 1'b0;
    #1 check("rst_from_fault", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RV);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    model_pc = RV;

    for (int i = 0; i < 3; i++) begin
      noise();
      bus.imem_ack = 1'b0;
      cyc("fetch_pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, model_pc);
    end
    rst = 1'b0;
    #1 check("rst_mid_fetch", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RV);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    model_pc = RV;
    v = '{0, 0, 0, 8'hCC, 0, 0, 8'h11};
    run_instr(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
